overture_sequencer: RTL

- Fetch/decode/register-file stage that sits directly upstream and downstream of the ALU.
- Fetches 8-bit instructions from a synchronous program ROM and holds six 8-bit general registers r0–r5.
- Issues calculate instructions to the ALU, which is clocked by the same clock and registers its result one edge later, then writes the ALU result back to r3.
- Also handles immediate loads, register copies, byte input/output with handshakes, and conditional jumps.

---
 rtl/overture_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/overture_sequencer.sv
// Fetch/decode/register-file stage wrapped around an external registered ALU.
// Runs 8-bit instructions from a synchronous ROM against six 8-bit registers r0-r5.
module overture_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {FETCH, DECODE, ALU_ISSUE, ALU_WB, IN_WAIT} state_t;

    localparam logic [1:0] MD_IMM  = 2'b00;
    localparam logic [1:0] MD_CALC = 2'b01;
    localparam logic [1:0] MD_COPY = 2'b10;
    localparam logic [1:0] MD_COND = 2'b11;
    localparam logic [2:0] IDX_IO  = 3'd6;

    state_t     state;
    logic [7:0] instr;
    logic [7:0] regs [0:5];

    logic [7:0] cur;
    logic [1:0] md;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] src_val;
    logic [7:0] pc_next;
    logic       r3_zero;
    logic       r3_neg;
    logic       taken;

    // ROM data is only valid in DECODE; later states work from the latched copy.
    assign cur       = (state == DECODE) ? imem_data : instr;
    assign md        = cur[7:6];
    assign src       = cur[5:3];
    assign dst       = cur[2:0];
    assign pc_next   = pc + 8'd1;
    assign imem_addr = pc;
    assign r3_zero   = (regs[3] == 8'h00);
    assign r3_neg    = regs[3][7];

    // Index 6 reads the input port, index 7 reads as zero.
    always_comb begin
        src_val = 8'h00;
        if (src < IDX_IO)
            src_val = regs[src];
        else if (src == IDX_IO)
            src_val = in_data;
    end

    always_comb begin
        taken = 1'b0;
        case (cur[2:0])
            3'd0: taken = 1'b0;
            3'd1: taken = r3_zero;
            3'd2: taken = r3_neg;
            3'd3: taken = r3_neg | r3_zero;
            3'd4: taken = 1'b1;
            3'd5: taken = ~r3_zero;
            3'd6: taken = ~r3_neg;
            3'd7: taken = ~r3_neg & ~r3_zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (state == IN_WAIT)
            in_ready = in_valid;
        else if (state == DECODE && md == MD_COPY && src == IDX_IO)
            in_ready = in_valid;
    end

    // NOTE: the register file is only six bytes, so it is reset like any other
    // flop; larger memories would be left unreset and initialised by software.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            instr      <= 8'h00;
            alu_opcode <= 3'b000;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            for (int i = 0; i < 6; i++)
                regs[i] <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (run)
                        state <= DECODE;
                end
                DECODE: begin
                    instr <= imem_data;
                    case (md)
                        MD_IMM: begin
                            regs[0] <= {2'b00, imem_data[5:0]};
                            pc      <= pc_next;
                            state   <= FETCH;
                        end
                        MD_CALC: begin
                            alu_opcode <= imem_data[2:0];
                            alu_a      <= regs[1];
                            alu_b      <= regs[2];
                            state      <= ALU_ISSUE;
                        end
                        MD_COPY: begin
                            if (src == IDX_IO && !in_valid) begin
                                state <= IN_WAIT;
                            end else begin
                                if (dst < IDX_IO)
                                    regs[dst] <= src_val;
                                else if (dst == IDX_IO) begin
                                    out_data  <= src_val;
                                    out_valid <= 1'b1;
                                end
                                pc    <= pc_next;
                                state <= FETCH;
                            end
                        end
                        default: begin
                            pc    <= taken ? regs[0] : pc_next;
                            state <= FETCH;
                        end
                    endcase
                end
                ALU_ISSUE: state <= ALU_WB;
                ALU_WB: begin
                    regs[3] <= alu_result;
                    pc      <= pc_next;
                    state   <= FETCH;
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        if (dst < IDX_IO)
                            regs[dst] <= src_val;
                        else if (dst == IDX_IO) begin
                            out_data  <= src_val;
                            out_valid <= 1'b1;
                        end
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
